// File: rtl/ide_pkg.sv
// Shared IDE sector-buffer geometry and drain-engine types.
// Used by the buffer, the write-side block and the read-side drain.
package ide_pkg;

  localparam int unsigned IDE_BUF_ADDR_W = 9;
  localparam int unsigned IDE_BUF_DATA_W = 16;
  localparam int unsigned IDE_BUF_DEPTH  = 512;

  typedef enum logic {
    DRAIN_IDLE,
    DRAIN_RUN
  } drain_state_e;

endpackage

// File: rtl/ide_data_drain_if.sv
// Control, buffer read port and host strobe signals of the IDE read-side drain.
// master = drain engine, slave = controller/buffer/host side.
interface ide_data_drain_if
  import ide_pkg::*;
#(
  parameter int unsigned ADDR_W = IDE_BUF_ADDR_W,
  parameter int unsigned DATA_W = IDE_BUF_DATA_W
) ();

  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   word_count;
  logic              abort;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic [DATA_W-1:0] data_out;
  logic              drq;
  logic              rd_strobe;
  logic              busy;
  logic              done;
  logic              underrun;

  modport master (
    input  start, start_addr, word_count, abort, buf_data, rd_strobe,
    output buf_addr, data_out, drq, busy, done, underrun
  );

  modport slave (
    output start, start_addr, word_count, abort, buf_data, rd_strobe,
    input  buf_addr, data_out, drq, busy, done, underrun
  );

endinterface

// File: rtl/ide_drain_skid.sv
// Two-entry holding queue between the buffer read port and the host data register.
// Owns occupancy; room says whether another read may be issued this cycle.
module ide_drain_skid
  import ide_pkg::*;
#(
  parameter int unsigned DATA_W = IDE_BUF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  input  logic              in_flight,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head,
  output logic              room
);

  logic [DATA_W-1:0] e0, e1;
  logic [1:0]        count_q;
  logic [2:0]        occ_next;

  always_comb begin
    occ_next = 3'(count_q) + 3'(push) - 3'(pop);
    // the word fetched in the next cycle lands after in_flight has been pushed
    room     = (occ_next + 3'(in_flight)) < 3'd2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e0      <= '0;
      e1      <= '0;
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      count_q <= occ_next[1:0];
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) e0 <= push_data;
          else                 e1 <= push_data;
        end
        2'b01: begin
          // a single-entry pop leaves the head in place so data_out holds the last word
          if (count_q == 2'd2) e0 <= e1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            e0 <= push_data;
          end else begin
            e0 <= e1;
            e1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = count_q;
  assign head  = e0;

endmodule

// File: rtl/ide_data_drain.sv
// Read-side streaming engine: drains a programmed run of buffer words to the host
// data register, one word per cycle, hiding the buffer's registered read latency.
module ide_data_drain
  import ide_pkg::*;
#(
  parameter int unsigned ADDR_W = IDE_BUF_ADDR_W,
  parameter int unsigned DATA_W = IDE_BUF_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  ide_data_drain_if.master     bus
);

  drain_state_e      state;
  logic [ADDR_W-1:0] fetch_ptr;
  logic [ADDR_W:0]   fetch_left;
  logic [ADDR_W:0]   xfer_left;
  logic              ret_q;
  logic              done_q;
  logic              underrun_q;

  logic [1:0]        q_count;
  logic [DATA_W-1:0] q_head;
  logic              room;
  logic              drq;
  logic              pop;
  logic              issue;
  logic              accept_start;

  assign drq          = (q_count != 2'd0);
  assign pop          = bus.rd_strobe && drq;
  assign accept_start = bus.start && !bus.abort && (state == DRAIN_IDLE);

  // buf_addr shows fetch_ptr continuously; a cycle counts as a read only when issue is set
  assign issue = (state == DRAIN_RUN) && (fetch_left != '0) && room;

  ide_drain_skid #(.DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (ret_q),
    .push_data (bus.buf_data),
    .pop       (pop),
    .flush     (bus.abort),
    .in_flight (1'b0),
    .count     (q_count),
    .head      (q_head),
    .room      (room)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DRAIN_IDLE;
      fetch_ptr  <= '0;
      fetch_left <= '0;
      xfer_left  <= '0;
      ret_q      <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ret_q  <= issue && !bus.abort;

      if (accept_start)                 underrun_q <= 1'b0;
      else if (bus.rd_strobe && !drq)   underrun_q <= 1'b1;

      if (bus.abort) begin
        state <= DRAIN_IDLE;
      end else begin
        unique case (state)
          DRAIN_IDLE: begin
            if (bus.start) begin
              fetch_ptr  <= bus.start_addr;
              fetch_left <= bus.word_count;
              xfer_left  <= bus.word_count;
              if (bus.word_count != '0) state  <= DRAIN_RUN;
              else                      done_q <= 1'b1;
            end
          end
          DRAIN_RUN: begin
            if (issue) begin
              fetch_ptr  <= fetch_ptr + ADDR_W'(1);
              fetch_left <= fetch_left - (ADDR_W+1)'(1);
            end
            if (pop) begin
              xfer_left <= xfer_left - (ADDR_W+1)'(1);
              if (xfer_left == (ADDR_W+1)'(1)) begin
                state  <= DRAIN_IDLE;
                done_q <= 1'b1;
              end
            end
          end
          default: state <= DRAIN_IDLE;
        endcase
      end
    end
  end

  assign bus.buf_addr = fetch_ptr;
  assign bus.data_out = q_head;
  assign bus.drq      = drq;
  assign bus.busy     = (state == DRAIN_RUN);
  assign bus.done     = done_q;
  assign bus.underrun = underrun_q;

endmodule

// File: doc/ide_data_drain.md
# ide_data_drain

Read-side streaming engine for the IDE sector data buffer: drains a programmed run of 16-bit words from the buffer toward the host data register during PIO data-in transfers. It drives the buffer read address and absorbs the buffer's one-cycle registered read latency. It presents words on a strobe handshake, sustaining one word per cycle with no bubbles. It sits between the buffer read port and the host-side IDE register/strobe logic; the controller CPU programs the start address and word count.

## Interface
- ADDR_W, 9, buffer address width (512-word buffer)
- DATA_W, 16, word width
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latch start_addr/word_count and begin a run (ignored while busy)
- start_addr  in  ADDR_W  first buffer address of the run
- word_count  in  ADDR_W+1  words to transfer, 0..512; 0 = empty run
- abort  in  1  terminate current run; no done pulse
- buf_addr  out  ADDR_W  buffer read address
- buf_data  in  DATA_W  buffer read data; valid the cycle after buf_addr was presented
- data_out  out  DATA_W  current word for host
- drq  out  1  data_out valid; host may strobe
- rd_strobe  in  1  one-cycle pulse; host consumes data_out
- busy  out  1  run in progress
- done  out  1  one-cycle pulse after last word consumed
- underrun  out  1  sticky: rd_strobe seen while drq low; cleared by start or rst

## Operation
- States: IDLE, RUN. start in IDLE with word_count≠0 -> RUN; with word_count=0 -> stays IDLE, done pulses next cycle.
- RUN holds fetch_ptr, fetch_left (words not yet requested), xfer_left (words not yet consumed).
- Issue rule: a read is issued in a cycle when fetch_left>0 and (held + in-flight − consumed-this-cycle) < 2. Issue presents fetch_ptr on buf_addr, then increments fetch_ptr and decrements fetch_left.
- The returning word enters a 2-entry holding queue. Head of queue drives data_out; drq = queue non-empty.
- rd_strobe with drq high pops the head and decrements xfer_left. xfer_left reaching 0 -> IDLE, busy low, done pulse the same cycle busy falls.
- rd_strobe with drq low: ignored for data, sets underrun.
- fetch_ptr wraps 511 -> 0; a run of 512 from any address reads every word exactly once.
- abort (any state): queue flushed, drq low, -> IDLE next cycle, no done. start in the same cycle as abort is ignored.
- start while busy: ignored, no state change.
- Reset values: buf_addr 0, data_out 0, drq 0, busy 0, done 0, underrun 0, state IDLE, queue empty.

## Timing
- start sampled at edge E0: busy high from cycle 1. First read issued in cycle 1 (buf_addr = start_addr). buf_data valid cycle 2. drq high and data_out = word[start_addr] in cycle 3.
- rd_strobe held high every cycle from cycle 3: data_out advances one word per cycle with drq continuously high. Last word consumed in cycle 3+N−1. done pulse and busy low in cycle 3+N.
- rd_strobe pops at edge; next word visible the following cycle if queued.
- Stalled host: at most 2 words held plus none in flight; fetching resumes the cycle a slot frees.
- rst mid-run: all outputs return to reset values at the next edge; buffer contents are untouched.

## Structure
- Shared ide_pkg: IDE_BUF_ADDR_W=9, IDE_BUF_DATA_W=16, IDE_BUF_DEPTH=512 (also used by the buffer and the write-side block).
- Sub-module ide_drain_skid: 2-entry queue with push/pop/flush, count output, head data. Owns the occupancy arithmetic. The top level owns the counters, state, and issue logic.

## Test plan
- start_addr=0x010, word_count=4, rd_strobe every cycle from drq -> drq high cycles 3–6, data_out = buf[0x10..0x13], done in cycle 7.
- start_addr=0x1FE, word_count=4 -> buf_addr sequence 0x1FE,0x1FF,0x000,0x001; data in that order.
- word_count=512, host strobes every 3rd cycle -> all 512 words in order, queue never exceeds 2, no duplicate or missed address.
- word_count=0 -> no drq, busy stays low, done pulses cycle 1.
- abort after 2 of 8 words consumed -> drq low next cycle, no done. A following start with 3 words from 0x100 delivers buf[0x100..0x102] only.
- rd_strobe while drq low -> underrun=1, data unaffected. rst mid-run -> all outputs at reset values, underrun 0.
